// File: rtl/asic_bridge_pkg.sv
// Shared types and default geometry for the ASIC configuration bridge.
package asic_bridge_pkg;

  localparam int DEF_SIZESRSTAT = 88;
  localparam int DEF_SIZESRDYN  = 16;
  localparam int DEF_CLK_DIV    = 4;

  typedef enum logic [2:0] {
    ST_WAIT_START,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/asic_bridge_top_spi_shift_engine.sv
// Width-parameterised serial shifter: divided clock, MSB-first MOSI,
// LSB-in MISO capture, shift-end and frame-done strobes.
module spi_shift_engine #(
  parameter int W   = 88,
  parameter int DIV = 4,
  parameter int LW  = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [LW-1:0] len,
  input  logic [W-1:0]  word,
  input  logic          miso,
  output logic          sclk,
  output logic          mosi,
  output logic          shift_end,
  output logic          done,
  output logic [W-1:0]  rx
);

  localparam int HALF = DIV / 2;
  localparam int PW   = $clog2(DIV);

  logic          active_q, active_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [LW-1:0] bit_q, bit_d;
  logic [LW-1:0] len_q, len_d;
  logic [W-1:0]  tx_q, tx_d;
  logic [W-1:0]  rx_q, rx_d;

  logic          cur_act;
  logic [PW-1:0] cur_ph;
  logic [LW-1:0] cur_bit, cur_len;
  logic [W-1:0]  cur_tx, cur_rx;
  logic          in_bits, rise, fall;

  // The load cycle is treated as phase 0 of bit 0, so the frame
  // timing is uniform from the first cycle of the select window.
  always_comb begin
    cur_act = load | active_q;
    cur_ph  = load ? '0 : ph_q;
    cur_bit = load ? '0 : bit_q;
    cur_len = load ? len : len_q;
    cur_tx  = load ? word : tx_q;
    cur_rx  = load ? '0 : rx_q;

    in_bits   = cur_bit < cur_len;
    rise      = cur_act && in_bits && (cur_ph == PW'(HALF - 1));
    fall      = cur_act && in_bits && (cur_ph == PW'(DIV - 1));
    shift_end = fall && (cur_bit == cur_len - LW'(1));
    done      = cur_act && !in_bits && (cur_ph == PW'(HALF - 1));
    sclk      = cur_act && in_bits && (cur_ph >= PW'(HALF));
    mosi      = cur_tx[W-1];
    rx        = rx_q;

    active_d = cur_act && !done;
    len_d    = cur_len;
    tx_d     = fall ? {cur_tx[W-2:0], 1'b0} : cur_tx;
    rx_d     = rise ? {cur_rx[W-2:0], miso} : cur_rx;
    ph_d     = ph_q;
    bit_d    = bit_q;
    if (cur_act) begin
      if (cur_ph == PW'(DIV - 1)) begin
        ph_d  = '0;
        bit_d = cur_bit + LW'(1);
      end else begin
        ph_d  = cur_ph + PW'(1);
        bit_d = cur_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      ph_q     <= '0;
      bit_q    <= '0;
      len_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      len_q    <= len_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: rtl/asic_bridge_top.sv
// Serial configuration master for the ASIC static/dynamic shift registers:
// request edge capture, transfer FSM, word selection and readback compare.
module asic_bridge_top
  import asic_bridge_pkg::*;
#(
  parameter int SIZESRSTAT = DEF_SIZESRSTAT,
  parameter int SIZESRDYN  = DEF_SIZESRDYN,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start_ASIC_config,
  input  logic                  flag_stat,
  input  logic                  flag_dyn,
  input  logic [SIZESRSTAT-1:0] static_conf_ear,
  input  logic [SIZESRDYN-1:0]  dynamic_conf,
  input  logic                  miso_input,
  output logic                  clk_output,
  output logic                  mosi_output,
  output logic                  sel_output,
  output logic                  xor_out_stat,
  output logic                  xor_out_dyn,
  output logic                  end_config
);

  localparam int W  = max_int(SIZESRSTAT, SIZESRDYN);
  localparam int LW = $clog2(W + 1);

  state_t state_q, state_d;

  logic fs_sync_q, fs_sync_d, fs_prev_q, fs_prev_d;
  logic fd_sync_q, fd_sync_d, fd_prev_q, fd_prev_d;
  logic pend_stat_q, pend_stat_d;
  logic pend_dyn_q, pend_dyn_d;
  logic is_stat_q, is_stat_d;
  logic xs_q, xs_d, xd_q, xd_d;

  logic [W-1:0]          sent_q, sent_d;
  logic [SIZESRSTAT-1:0] last_stat_q, last_stat_d;
  logic [SIZESRDYN-1:0]  last_dyn_q, last_dyn_d;

  logic          eng_load, eng_sclk, eng_mosi;
  logic          eng_shift_end, eng_done;
  logic [LW-1:0] eng_len;
  logic [W-1:0]  eng_word, eng_rx;

  spi_shift_engine #(
    .W   (W),
    .DIV (CLK_DIV),
    .LW  (LW)
  ) u_engine (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (eng_load),
    .len       (eng_len),
    .word      (eng_word),
    .miso      (miso_input),
    .sclk      (eng_sclk),
    .mosi      (eng_mosi),
    .shift_end (eng_shift_end),
    .done      (eng_done),
    .rx        (eng_rx)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_WAIT_START;
      fs_sync_q   <= 1'b0;
      fs_prev_q   <= 1'b0;
      fd_sync_q   <= 1'b0;
      fd_prev_q   <= 1'b0;
      pend_stat_q <= 1'b0;
      pend_dyn_q  <= 1'b0;
      is_stat_q   <= 1'b0;
      xs_q        <= 1'b0;
      xd_q        <= 1'b0;
      sent_q      <= '0;
      last_stat_q <= '0;
      last_dyn_q  <= '0;
    end else begin
      state_q     <= state_d;
      fs_sync_q   <= fs_sync_d;
      fs_prev_q   <= fs_prev_d;
      fd_sync_q   <= fd_sync_d;
      fd_prev_q   <= fd_prev_d;
      pend_stat_q <= pend_stat_d;
      pend_dyn_q  <= pend_dyn_d;
      is_stat_q   <= is_stat_d;
      xs_q        <= xs_d;
      xd_q        <= xd_d;
      sent_q      <= sent_d;
      last_stat_q <= last_stat_d;
      last_dyn_q  <= last_dyn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT_START: if (start_ASIC_config) state_d = ST_IDLE;
      ST_IDLE:       if (pend_stat_q || pend_dyn_q) state_d = ST_LOAD;
      ST_LOAD:       state_d = ST_SHIFT;
      ST_SHIFT:      if (eng_shift_end) state_d = ST_TRAIL;
      ST_TRAIL:      if (eng_done) state_d = ST_DONE;
      ST_DONE:       state_d = ST_WAIT_START;
      default:       state_d = ST_WAIT_START;
    endcase
  end

  // A new edge wins over the clear so a request landing on the
  // IDLE->LOAD edge is not lost.
  always_comb begin
    fs_sync_d   = flag_stat;
    fs_prev_d   = fs_sync_q;
    fd_sync_d   = flag_dyn;
    fd_prev_d   = fd_sync_q;
    pend_stat_d = pend_stat_q;
    pend_dyn_d  = pend_dyn_q;
    is_stat_d   = is_stat_q;
    if (state_q == ST_IDLE) begin
      if (pend_stat_q) begin
        is_stat_d   = 1'b1;
        pend_stat_d = 1'b0;
      end else if (pend_dyn_q) begin
        is_stat_d  = 1'b0;
        pend_dyn_d = 1'b0;
      end
    end
    if (fs_sync_q && !fs_prev_q) pend_stat_d = 1'b1;
    if (fd_sync_q && !fd_prev_q) pend_dyn_d = 1'b1;
  end

  always_comb begin
    eng_load = (state_q == ST_LOAD);
    eng_len  = is_stat_q ? LW'(SIZESRSTAT) : LW'(SIZESRDYN);
    eng_word = is_stat_q ? (W'(static_conf_ear) << (W - SIZESRSTAT))
                         : (W'(dynamic_conf) << (W - SIZESRDYN));
    sent_d   = sent_q;
    if (eng_load) begin
      sent_d = is_stat_q ? W'(static_conf_ear) : W'(dynamic_conf);
    end
    xs_d        = xs_q;
    xd_d        = xd_q;
    last_stat_d = last_stat_q;
    last_dyn_d  = last_dyn_q;
    if (state_q == ST_TRAIL && eng_done) begin
      if (is_stat_q) begin
        xs_d        = |(eng_rx[SIZESRSTAT-1:0] ^ last_stat_q);
        last_stat_d = sent_q[SIZESRSTAT-1:0];
      end else begin
        xd_d       = |(eng_rx[SIZESRDYN-1:0] ^ last_dyn_q);
        last_dyn_d = sent_q[SIZESRDYN-1:0];
      end
    end
  end

  always_comb begin
    sel_output = 1'b1;
    end_config = 1'b0;
    unique case (state_q)
      ST_LOAD, ST_SHIFT, ST_TRAIL: sel_output = 1'b0;
      ST_DONE:                     end_config = 1'b1;
      default: ;
    endcase
    clk_output   = eng_sclk;
    mosi_output  = sel_output ? 1'b0 : eng_mosi;
    xor_out_stat = xs_q;
    xor_out_dyn  = xd_q;
  end

endmodule

// File: tb/tb_asic_bridge_top.sv
// Directed + randomized bench for asic_bridge_top with a loopback ASIC model.
`timescale 1ns/1ps
module tb_asic_bridge_top;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start_ASIC_config = 1'b0;
  logic        flag_stat = 1'b0;
  logic        flag_dyn = 1'b0;
  logic [87:0] static_conf_ear = '0;
  logic [15:0] dynamic_conf = '0;
  logic        miso_input;
  logic        clk_output, mosi_output, sel_output;
  logic        xor_out_stat, xor_out_dyn, end_config;

  asic_bridge_top dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .start_ASIC_config (start_ASIC_config),
    .flag_stat         (flag_stat),
    .flag_dyn          (flag_dyn),
    .static_conf_ear   (static_conf_ear),
    .dynamic_conf      (dynamic_conf),
    .miso_input        (miso_input),
    .clk_output        (clk_output),
    .mosi_output       (mosi_output),
    .sel_output        (sel_output),
    .xor_out_stat      (xor_out_stat),
    .xor_out_dyn       (xor_out_dyn),
    .end_config        (end_config)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // ASIC model: two shift registers; miso is the MSB of the selected one.
  int          mode = 0;
  bit          cur_stat = 1'b1;
  logic [87:0] asic_s = '0;
  logic [15:0] asic_d = '0;

  always @(posedge clk_output) begin
    if (cur_stat) asic_s <= {asic_s[86:0], mosi_output};
    else          asic_d <= {asic_d[14:0], mosi_output};
  end

  assign miso_input = (mode == 0) ? 1'b0 :
    ((cur_stat ? asic_s[87] : asic_d[15]) ^ (mode == 2));

  logic [87:0] last_s = '0;
  logic [15:0] last_d = '0;
  logic        xs_ref = 1'b0;
  logic        xd_ref = 1'b0;

  int          m_lat, m_sel_low, m_rises, m_ends, m_mosi_bad;
  logic        m_end_ok, m_to;
  logic [87:0] m_tx, m_rx;

  task automatic chk(input string tag, input logic [87:0] obs,
                     input logic [87:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic measure(input int budget);
    logic prev_clk, prev_miso;
    bit   seen_low;
    m_lat = -1; m_sel_low = 0; m_rises = 0; m_ends = 0; m_mosi_bad = 0;
    m_end_ok = 1'b0; m_to = 1'b1; m_tx = '0; m_rx = '0;
    prev_clk = clk_output; prev_miso = miso_input; seen_low = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge CLK);
      if (end_config) m_ends++;
      if (sel_output && mosi_output) m_mosi_bad++;
      if (!sel_output) begin
        if (!seen_low) m_lat = n;
        seen_low = 1'b1;
        m_sel_low++;
      end
      if (clk_output && !prev_clk) begin
        m_rises++;
        m_tx = {m_tx[86:0], mosi_output};
        m_rx = {m_rx[86:0], prev_miso};
      end
      if (seen_low && sel_output) begin
        m_end_ok = end_config;
        m_to = 1'b0;
        break;
      end
      prev_clk = clk_output;
      prev_miso = miso_input;
    end
    repeat (2) begin
      @(negedge CLK);
      if (end_config) m_ends++;
    end
  endtask

  task automatic xfer(input bit st, input logic [87:0] w, input bit hold);
    cur_stat = st;
    if (st) static_conf_ear = w;
    else    dynamic_conf = w[15:0];
    flag_stat = 1'b0;
    flag_dyn = 1'b0;
    @(negedge CLK);
    if (st) flag_stat = 1'b1;
    else    flag_dyn = 1'b1;
    measure(700);
    if (!hold) begin
      flag_stat = 1'b0;
      flag_dyn = 1'b0;
    end
  endtask

  task automatic check_xfer(input bit st, input logic [87:0] w,
                            input bit chk_lat);
    int n;
    n = st ? 88 : 16;
    chk("timeout", 88'(m_to), 88'd0);
    if (chk_lat) chk("latency", 88'(m_lat), 88'd3);
    chk("sel_low", 88'(m_sel_low), 88'(n * 4 + 2));
    chk("clk_rises", 88'(m_rises), 88'(n));
    chk("mosi_idle", 88'(m_mosi_bad), 88'd0);
    if (st) chk("mosi_stat", m_tx, w);
    else    chk("mosi_dyn", 88'(m_tx[15:0]), 88'(w[15:0]));
    chk("end_pulses", 88'(m_ends), 88'd1);
    chk("end_at_sel_high", 88'(m_end_ok), 88'd1);
    if (st) begin
      xs_ref = (m_rx != last_s);
      last_s = w;
    end else begin
      xd_ref = (m_rx[15:0] != last_d);
      last_d = w[15:0];
    end
    chk("xor_stat", 88'(xor_out_stat), 88'(xs_ref));
    chk("xor_dyn", 88'(xor_out_dyn), 88'(xd_ref));
  endtask

  initial begin
    logic [95:0] r96;
    logic [87:0] w;
    bit          st;
    int          cnt, rises;
    logic        prevc;

    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_sel", 88'(sel_output), 88'd1);
    chk("rst_clk", 88'(clk_output), 88'd0);
    chk("rst_mosi", 88'(mosi_output), 88'd0);
    chk("rst_end", 88'(end_config), 88'd0);
    chk("rst_xs", 88'(xor_out_stat), 88'd0);
    chk("rst_xd", 88'(xor_out_dyn), 88'd0);

    start_ASIC_config = 1'b1;
    repeat (2) @(negedge CLK);

    mode = 0;
    xfer(1'b1, 88'hF123456789ABCDEF012F, 1'b0);
    check_xfer(1'b1, 88'hF123456789ABCDEF012F, 1'b1);
    chk("first_xs_zero", 88'(xor_out_stat), 88'd0);

    xfer(1'b0, 88'hF5AF, 1'b0);
    check_xfer(1'b0, 88'hF5AF, 1'b1);
    chk("first_xd_zero", 88'(xor_out_dyn), 88'd0);

    mode = 1;
    xfer(1'b1, 88'hFACEB00C1234567890DF, 1'b0);
    check_xfer(1'b1, 88'hFACEB00C1234567890DF, 1'b1);
    chk("readback_s", m_rx, 88'hF123456789ABCDEF012F);
    chk("loop_xs_zero", 88'(xor_out_stat), 88'd0);

    mode = 2;
    xfer(1'b1, 88'h0123_4567_89AB_CDEF_0011_22, 1'b0);
    check_xfer(1'b1, 88'h0123_4567_89AB_CDEF_0011_22, 1'b1);
    chk("corrupt_xs_one", 88'(xor_out_stat), 88'd1);
    mode = 1;

    xfer(1'b1, 88'h5A5A_5A5A_5A5A_5A5A_5A5A_5A, 1'b1);
    check_xfer(1'b1, 88'h5A5A_5A5A_5A5A_5A5A_5A5A_5A, 1'b1);
    cnt = 0; rises = 0;
    repeat (40) begin
      @(negedge CLK);
      if (!sel_output) cnt++;
      if (end_config) rises++;
    end
    chk("held_no_sel", 88'(cnt), 88'd0);
    chk("held_no_end", 88'(rises), 88'd0);
    flag_stat = 1'b0;
    @(negedge CLK);

    static_conf_ear = 88'h77_0000_1111_2222_3333_4444;
    dynamic_conf = 16'h1234;
    cur_stat = 1'b1;
    @(negedge CLK);
    flag_stat = 1'b1;
    flag_dyn = 1'b1;
    measure(700);
    check_xfer(1'b1, 88'h77_0000_1111_2222_3333_4444, 1'b1);
    cur_stat = 1'b0;
    measure(700);
    check_xfer(1'b0, 88'h1234, 1'b0);
    flag_stat = 1'b0;
    flag_dyn = 1'b0;

    for (int i = 0; i < 5; i++) begin
      r96 = {$urandom(), $urandom(), $urandom()};
      w = r96[87:0];
      st = bit'($urandom_range(0, 1));
      mode = ($urandom_range(0, 3) == 0) ? 2 : 1;
      xfer(st, w, 1'b0);
      check_xfer(st, w, 1'b1);
    end
    mode = 1;

    r96 = {$urandom(), $urandom(), $urandom()};
    cur_stat = 1'b1;
    static_conf_ear = r96[87:0];
    @(negedge CLK);
    flag_stat = 1'b1;
    rises = 0;
    prevc = clk_output;
    for (int n = 0; n < 1000 && rises < 40; n++) begin
      @(negedge CLK);
      if (clk_output && !prevc) rises++;
      prevc = clk_output;
    end
    chk("abort_reach_bit40", 88'(rises), 88'd40);
    RST_N = 1'b0;
    #2;
    chk("abort_sel", 88'(sel_output), 88'd1);
    chk("abort_clk", 88'(clk_output), 88'd0);
    chk("abort_mosi", 88'(mosi_output), 88'd0);
    chk("abort_xs", 88'(xor_out_stat), 88'd0);
    cnt = 0;
    repeat (4) begin
      @(negedge CLK);
      if (end_config) cnt++;
    end
    flag_stat = 1'b0;
    RST_N = 1'b1;
    last_s = '0; last_d = '0; xs_ref = 1'b0; xd_ref = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      if (end_config) cnt++;
    end
    chk("abort_no_end", 88'(cnt), 88'd0);

    r96 = {$urandom(), $urandom(), $urandom()};
    xfer(1'b1, r96[87:0], 1'b0);
    check_xfer(1'b1, r96[87:0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
